// File: rtl/kuz_pkg.sv
// Shared constants for the Kuznyechik linear layer: l-coefficients, field polynomial,
// round count and the converter state encoding.
package kuz_pkg;

  localparam logic [8:0] GF_POLY = 9'h1C3;
  localparam int         ROUNDS  = 16;
  localparam int         CNT_W   = 4;

  // Byte k of L_COEF is the coefficient applied to input byte a_k (a15 in the top byte).
  localparam logic [15:0][7:0] L_COEF = {
    8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
    8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gf_mul8.sv
// Combinational GF(2^8) multiplier, reduction polynomial x^8+x^7+x^6+x+1.
module gf_mul8
  import kuz_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] acc_s;
  logic [7:0] sh_s;

  // Shift-and-add: sh_s walks through a*x^i, folded back into the field each step.
  always_comb begin
    acc_s = 8'd0;
    sh_s  = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        acc_s = acc_s ^ sh_s;
      end else begin
        acc_s = acc_s;
      end
      if (sh_s[7]) begin
        sh_s = {sh_s[6:0], 1'b0} ^ GF_POLY[7:0];
      end else begin
        sh_s = {sh_s[6:0], 1'b0};
      end
    end
  end

  assign p_o = acc_s;

endmodule

// File: rtl/l_convertion.sv
// Kuznyechik L transform (16 R steps) as a request/finish sequencer.
// Optional L_CONV_DOUBLE_STEP_EN: two R steps per BUSY edge, same result in half the cycles.
module l_convertion
  import kuz_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [127:0] input_word,
  output logic [127:0] output_word,
  output logic         finish_convertion
);

`ifdef L_CONV_DOUBLE_STEP_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - STEPS);
  localparam logic [CNT_W-1:0] STEP_INC = CNT_W'(STEPS);

  state_e               state_q;
  logic [127:0]         work_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [STEPS:0][127:0] stg_s;

  assign stg_s[0] = work_q;

  // Chain of R steps; stage s feeds stage s+1 within one clock.
  for (genvar s = 0; s < STEPS; s++) begin : g_stage
    logic [15:0][7:0] prod_s;
    logic [7:0]       l_s;

    for (genvar k = 0; k < 16; k++) begin : g_mul
      gf_mul8 u_mul (
        .a_i (stg_s[s][8*k +: 8]),
        .b_i (L_COEF[k]),
        .p_o (prod_s[k])
      );
    end

    // Field sum of the sixteen weighted bytes.
    always_comb begin
      l_s = 8'd0;
      for (int k = 0; k < 16; k++) begin
        l_s = l_s ^ prod_s[k];
      end
    end

    assign stg_s[s+1] = {l_s, stg_s[s][127:8]};
  end

  // Sequencer: latch on request, step while held, publish result and hold until released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      work_q            <= 128'd0;
      cnt_q             <= '0;
      output_word       <= 128'd0;
      finish_convertion <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          finish_convertion <= 1'b0;
          if (enable) begin
            work_q  <= input_word;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!enable) begin
            finish_convertion <= 1'b0;
            state_q           <= ST_IDLE;
          end else begin
            work_q <= stg_s[STEPS];
            cnt_q  <= cnt_q + STEP_INC;
            if (cnt_q == LAST_CNT) begin
              output_word       <= stg_s[STEPS];
              finish_convertion <= 1'b1;
              state_q           <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_DONE: begin
          if (!enable) begin
            finish_convertion <= 1'b0;
            state_q           <= ST_IDLE;
          end else begin
            finish_convertion <= 1'b1;
            state_q           <= ST_DONE;
          end
        end
        default: begin
          finish_convertion <= 1'b0;
          state_q           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l_convertion.sv
// Directed bench for l_convertion with a scoreboard of model-computed L results.
module tb_l_convertion;

`ifdef L_CONV_DOUBLE_STEP_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam int LAT = 16 / STEPS + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [127:0] input_word;
  logic [127:0] output_word;
  logic         finish_convertion;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_exp = 128'd0;

  l_convertion dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .input_word        (input_word),
    .output_word       (output_word),
    .finish_convertion (finish_convertion)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Polynomial product then long division by 0x1C3.
  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'd0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h01C3 << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] m_r(input logic [127:0] x);
    logic [7:0] c [16];
    logic [7:0] l;
    c = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
          8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
    l = 8'd0;
    for (int k = 0; k < 16; k++) l = l ^ m_gmul(c[k], x[127 - 8*k -: 8]);
    return {l, x[127:8]};
  endfunction

  function automatic logic [127:0] m_l(input logic [127:0] x);
    logic [127:0] y;
    y = x;
    for (int i = 0; i < 16; i++) y = m_r(y);
    return y;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request: start, scramble input after latch, measure latency, check hold and release.
  task automatic run_req(input string tag, input logic [127:0] data);
    logic [127:0] exp_v;
    int n;
    @(negedge clk);
    input_word = data;
    enable     = 1'b1;
    exp_q.push_back(m_l(data));
    @(posedge clk);
    n = 1;
    #1;
    input_word = {$urandom, $urandom, $urandom, $urandom};
    while (!finish_convertion && n < LAT + 8) begin
      @(posedge clk);
      n++;
      #1;
    end
    check({tag, " latency"}, 128'(n), 128'(LAT));
    exp_v = exp_q.pop_front();
    check({tag, " result"}, output_word, exp_v);
    last_exp = exp_v;
    @(posedge clk);
    #1;
    check({tag, " hold finish"}, 128'(finish_convertion), 128'd1);
    check({tag, " hold result"}, output_word, exp_v);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " release finish"}, 128'(finish_convertion), 128'd0);
    check({tag, " release result"}, output_word, exp_v);
  endtask

  initial begin
    logic [127:0] v;
    bit seen;
    rst_n      = 1'b0;
    enable     = 1'b0;
    input_word = 128'd0;
    #12;
    check("reset output", output_word, 128'd0);
    check("reset finish", 128'(finish_convertion), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("kat", 128'h64a59400000000000000000000000000);
    check("kat const", output_word, 128'hd456584dd0e3e84cc3166e4b7fa2890d);

    run_req("zero", 128'd0);

    // Counter forced to its final value so only the last BUSY edge runs.
    @(negedge clk);
    input_word = 128'h00000000000000000000000000000100;
    enable     = 1'b1;
    @(posedge clk);
    #1;
    force dut.cnt_q = 4'(16 - STEPS);
    @(posedge clk);
    #1;
    release dut.cnt_q;
    check("single R finish", 128'(finish_convertion), 128'd1);
    if (STEPS == 1) check("single R", output_word, 128'h94000000000000000000000000000001);
    else check("double R", output_word, m_r(m_r(128'h00000000000000000000000000000100)));
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("single R release", 128'(finish_convertion), 128'd0);

    v = {$urandom, $urandom, $urandom, $urandom};
    run_req("b2b first", v);
    v = {$urandom, $urandom, $urandom, $urandom};
    run_req("b2b second", v);

    // Abort after five BUSY edges.
    @(negedge clk);
    input_word = 128'h0123456789abcdeffedcba9876543210;
    enable     = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    seen   = 1'b0;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (finish_convertion) seen = 1'b1;
    end
    check("abort finish", 128'(seen), 128'd0);
    check("abort output kept", output_word, last_exp);
    run_req("after abort", 128'h0123456789abcdeffedcba9876543210);

    // Asynchronous reset between edges during BUSY.
    @(negedge clk);
    input_word = 128'hffffffffffffffffffffffffffffffff;
    enable     = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset output", output_word, 128'd0);
    check("async reset finish", 128'(finish_convertion), 128'd0);
    enable = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle after reset", 128'(finish_convertion), 128'd0);
    run_req("after reset", 128'hffffffffffffffffffffffffffffffff);
    run_req("a0 only", 128'h000000000000000000000000000000a5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/l_convertion.md
L_CONVERTION -- requirements
Module: l_convertion

Interface
REQ-001 The block SHALL have no parameters; all sizes are fixed constants from the shared package.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 enable  input  1  level request; high starts and holds a conversion.
REQ-005 input_word  input  128  operand; byte a15 = bits 127:120, byte a0 = bits 7:0.
REQ-006 output_word  output  128  registered result of L(input_word).
REQ-007 finish_convertion  output  1  registered flag; high = output_word valid for the current request.

Function
REQ-008 The block SHALL compute the Kuznyechik linear transform L = R applied 16 times (GOST R 34.12-2015).
REQ-009 One R step SHALL map a15..a0 to {l(a15..a0), a15, ..., a1}: shift right one byte, l-value into bits 127:120.
REQ-010 l SHALL be the GF(2^8) sum of coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1 times a15..a0 respectively.
REQ-011 GF(2^8) multiplication SHALL reduce modulo x^8+x^7+x^6+x+1 (0x1C3); addition SHALL be XOR.
REQ-012 States SHALL be IDLE, BUSY, DONE.
REQ-013 IDLE: on an edge with enable=1, latch input_word into a working register, clear the round counter, go to BUSY.
REQ-014 BUSY: each edge SHALL apply one R step and increment the counter; on the 16th step it SHALL load output_word, set finish_convertion=1, go to DONE.
REQ-015 Latency: finish_convertion SHALL be high 17 clock edges after the edge that sampled enable=1 in IDLE.
REQ-016 DONE: finish_convertion and output_word SHALL hold while enable=1; on an edge with enable=0 it SHALL clear finish_convertion and go to IDLE.
REQ-017 enable falling during BUSY SHALL abort: go to IDLE, finish_convertion stays 0, output_word keeps its previous value.
REQ-018 input_word changes after the latch edge SHALL NOT affect the result.
REQ-019 output_word SHALL only change on conversion completion or reset.
REQ-020 A new request SHALL need enable low for at least one sampled edge after DONE; enable held high in DONE SHALL NOT restart.

Reset
REQ-021 On rst_n=0, state SHALL go to IDLE and output_word, finish_convertion, working register and counter SHALL go to 0, independent of clk.
REQ-022 Reset mid-BUSY SHALL discard the conversion; after rst_n rises, the block SHALL wait in IDLE for enable.

Configuration
REQ-023 Macro L_CONV_DOUBLE_STEP_EN defined: BUSY SHALL apply two R steps per edge; finish_convertion high 9 edges after the start edge.
REQ-024 Macro absent: one R step per edge per REQ-014/015; results SHALL be identical in both builds.

Structure
REQ-025 Shared package kuz_pkg SHALL hold the 16 l-coefficients, polynomial 0x1C3, round count 16 and the state enumeration.
REQ-026 GF(2^8) multiply SHALL be the combinational sub-module gf_mul8 (two 8-bit inputs, 8-bit product); l SHALL use 16 instances or a constant-multiplier equivalent.
REQ-027 The S-box stage (table_convertion) SHALL stay a separate block and SHALL NOT be part of l_convertion.

Verification
REQ-028 input 64a59400000000000000000000000000, enable held high -> after 17 edges finish=1, output d456584dd0e3e84cc3166e4b7fa2890d.
REQ-029 input 0, enable high -> output 0, finish=1 at edge 17; enable low -> finish 0 next edge.
REQ-030 Single R check, counter forced to 15 via a debug bench hook: input 00000000000000000000000000000100 -> output 94000000000000000000000000000001.
REQ-031 enable dropped at edge 5 of BUSY -> finish never asserts, output_word unchanged; new request then yields the correct result.
REQ-032 rst_n pulsed low mid-BUSY between clock edges -> outputs 0 immediately; next request runs a full 17-edge conversion.
REQ-033 Back-to-back requests (enable low one edge between) with two vectors -> both results correct; run with and without L_CONV_DOUBLE_STEP_EN (latency 9).
